// File: rtl/alu_op_driver.sv
// alu_op_driver: valid/ready front end that issues one operation to a registered ALU and returns its result.
// Optional result checker is compiled in when the macro ALU_CHECK_EN is defined.
module alu_op_driver #(
  parameter int WIDTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_mode,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_mode,
  input  logic [WIDTH:0]   alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [7:0]       err_cnt,
  output logic             busy
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT, S_RESP} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_mode;
  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [WIDTH:0]   r_rsp_data;
  logic             r_rsp_valid;
  logic             w_accept;
  logic             w_capture;
  logic             w_release;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_capture = (r_state == S_CAPT);
  assign w_release = (r_state == S_RESP) && rsp_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_CAPT;
      S_CAPT:  w_state_next = S_RESP;
      S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand registers hold their last issued values; they change only on acceptance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_mode  <= '0;
      r_tag       <= '0;
      r_rsp_tag   <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a    <= req_a;
        r_alu_b    <= req_b;
        r_alu_mode <= req_mode;
        r_tag      <= req_tag;
      end
      if (w_capture) begin
        r_rsp_data  <= alu_y;
        r_rsp_tag   <= r_tag;
        r_rsp_valid <= 1'b1;
      end else if (w_release) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_mode  = r_alu_mode;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_tag   = r_rsp_tag;
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

`ifdef ALU_CHECK_EN
  localparam logic [WIDTH:0] ONE = 1;
  logic [WIDTH:0] w_expected;
  logic           w_mismatch;
  logic           r_rsp_err;
  logic [7:0]     r_err_cnt;

  always_comb begin
    w_expected = '0;
    case (r_alu_mode)
      2'd0:    w_expected = {1'b0, r_alu_a} + {1'b0, r_alu_b};
      2'd1:    w_expected = {1'b0, r_alu_a} - {1'b0, r_alu_b};
      2'd2:    w_expected = {1'b0, r_alu_a} + ONE;
      default: w_expected = {1'b0, r_alu_b} + ONE;
    endcase
  end

  assign w_mismatch = (alu_y != w_expected);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rsp_err <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_capture) begin
      r_rsp_err <= w_mismatch;
      if (w_mismatch && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign rsp_err = r_rsp_err;
  assign err_cnt = r_err_cnt;
`else
  assign rsp_err = 1'b0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_op_driver.sv
// Scoreboard bench for alu_op_driver with a behavioural registered ALU attached to its alu_* ports.
// Define ALU_CHECK_EN for both files to exercise the result checker.
module tb_alu_op_driver;
  localparam int W   = 4;
  localparam int TW  = 2;
  localparam int YW  = W + 1;
  localparam int MOD = 1 << YW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic [1:0]    req_mode = '0;
  logic [TW-1:0] req_tag = '0;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [1:0]    alu_mode;
  logic [W:0]    alu_y;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W:0]    rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_err;
  logic [7:0]    err_cnt;
  logic          busy;

  alu_op_driver #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic: plain integer maths reduced modulo 2^(W+1).
  function automatic int ref_alu(int a, int b, int m);
    int r;
    case (m)
      0: r = a + b;
      1: r = a - b;
      2: r = a + 1;
      default: r = b + 1;
    endcase
    r = r % MOD;
    if (r < 0) r += MOD;
    return r;
  endfunction

  // Registered ALU on the far side of the driver; corrupt forces Y to zero.
  bit corrupt = 1'b0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) alu_y <= '0;
    else       alu_y <= corrupt ? '0 : YW'(ref_alu(int'(alu_a), int'(alu_b), int'(alu_mode)));
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int data;
    int tag;
    int err;
    int ecnt;
    int acc;
  } exp_t;
  exp_t sb[$];
  int acc_count = 0;
  int last_acc = 0;
  int model_cnt = 0;
  bit seen = 1'b0;

  // Acceptance watcher: a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    if (rstn && req_valid && req_ready) begin
      exp_t e;
      int   r;
      r      = ref_alu(int'(req_a), int'(req_b), int'(req_mode));
      e.data = corrupt ? 0 : r;
      e.tag  = int'(req_tag);
      e.err  = 0;
`ifdef ALU_CHECK_EN
      if (e.data != r) begin
        e.err = 1;
        if (model_cnt < 255) model_cnt++;
      end
`endif
      e.ecnt = model_cnt;
      e.acc  = cyc + 1;
      sb.push_back(e);
      last_acc = cyc + 1;
      acc_count++;
      $display("REQ  cyc=%0d a=%0d b=%0d mode=%0d tag=%0d exp=%0d", cyc + 1, req_a, req_b, req_mode, req_tag, e.data);
    end
  end

  // Response monitor: compares every cycle rsp_valid is up, so held values are checked too.
  always @(negedge clk) begin
    if (rstn && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got data=%0d tag=%0d with nothing outstanding", rsp_data, rsp_tag);
      end else begin
        if (!seen) begin
          check("latency", cyc, sb[0].acc + 2);
          seen = 1'b1;
        end
        check("rsp_data", int'(rsp_data), sb[0].data);
        check("rsp_tag", int'(rsp_tag), sb[0].tag);
        check("rsp_err", int'(rsp_err), sb[0].err);
        check("err_cnt", int'(err_cnt), sb[0].ecnt);
        check("req_ready_in_resp", int'(req_ready), 0);
        if (rsp_ready) begin
          $display("RSP  cyc=%0d data=%0d tag=%0d err=%0d cnt=%0d", cyc, rsp_data, rsp_tag, rsp_err, err_cnt);
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic wait_acc(int prev);
    int n = 0;
    while (acc_count == prev && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (acc_count == prev) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no acceptance expected one within 40 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(int a, int b, int m, int t);
    int prev;
    prev      = acc_count;
    req_a     = W'(a);
    req_b     = W'(b);
    req_mode  = 2'(m);
    req_tag   = TW'(t);
    req_valid = 1'b1;
    wait_acc(prev);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_outstanding", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req_ready"}, int'(req_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_rsp_data"}, int'(rsp_data), 0);
    check({tag, "_rsp_tag"}, int'(rsp_tag), 0);
    check({tag, "_alu_a"}, int'(alu_a), 0);
    check({tag, "_alu_b"}, int'(alu_b), 0);
    check({tag, "_alu_mode"}, int'(alu_mode), 0);
    check({tag, "_rsp_err"}, int'(rsp_err), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  initial begin
    int prev;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    rsp_ready = 1'b1;

    // Directed arithmetic, including wrap and carry cases.
    do_op(7, 9, 0, 1);
    wait_drain();
    do_op(3, 5, 1, 2);
    do_op(15, 0, 2, 3);
    do_op(0, 4, 3, 0);
    wait_drain();
    check("alu_a_held", int'(alu_a), 0);
    check("alu_b_held", int'(alu_b), 4);
    check("alu_mode_held", int'(alu_mode), 3);

    // Backpressure with a competing request held by the source.
    rsp_ready = 1'b0;
    do_op(7, 2, 0, 2);
    for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge clk);
    check("bp_rsp_valid", int'(rsp_valid), 1);
    @(posedge clk);
    #1;
    req_a = 4'd5; req_b = 4'd5; req_mode = 2'd1; req_tag = 2'd3; req_valid = 1'b1;
    prev = acc_count;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("bp_req_ready", int'(req_ready), 0);
      check("bp_busy", int'(busy), 1);
      check("bp_no_accept", acc_count, prev);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_acc(prev);
    req_valid = 1'b0;
    wait_drain();

    // Back-to-back with req_valid held high.
    req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int prev_acc;
      prev_acc = last_acc;
      req_a = W'($urandom); req_b = W'($urandom); req_mode = 2'($urandom); req_tag = TW'($urandom);
      prev = acc_count;
      wait_acc(prev);
      if (k > 0) check("b2b_interval", last_acc - prev_acc, 4);
    end
    req_valid = 1'b0;
    wait_drain();

    // Random operations with random response stalls.
    for (int k = 0; k < 30; k++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      wait_drain();
    end

    // Reset while the operation is in its capture state aborts it.
    do_op(9, 9, 0, 2);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_reset_outputs("abort");
    sb.delete();
    seen      = 1'b0;
    model_cnt = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    do_op(2, 2, 0, 1);
    wait_drain();

`ifdef ALU_CHECK_EN
    corrupt = 1'b1;
    do_op(6, 0, 2, 1);
    wait_drain();
    corrupt = 1'b0;
    check("chk_err_cnt_after_fault", int'(err_cnt), 1);
    do_op(3, 3, 0, 2);
    wait_drain();
    check("chk_err_cnt_clean", int'(err_cnt), 1);
`endif

    repeat (3) @(posedge clk);
    check("final_outstanding", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000ns");
    $fatal(1, "timeout");
  end
endmodule
